eth_rx_word_packer: RTL and testbench

- Sits directly upstream of the Ethernet-to-DDR adapter, between the MAC receive byte interface and the 64-bit rxq word stream.
- Packs received frame bytes into 64-bit little-endian words and tags each word with aux bits: valid byte count, end-of-frame and error.
- Buffers words in a small FIFO because the MAC side cannot be stalled; overflow is reported in-band as a truncated/error frame.

---
 rtl/eth_rx_word_packer_if.sv | 11 +
 rtl/eth_rx_word_packer.sv | 217 +++++++++++++++++++++
 tb/tb_eth_rx_word_packer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_word_packer_if.sv
// Word stream between the Ethernet receive packer and its consumer.
// The packer drives the word/aux/valid side, the consumer drives ready.
interface eth_rx_word_packer_if;
  logic [63:0] rxq_bits;
  logic [7:0]  rxq_aux_bits;
  logic        rxq_val;
  logic        rxq_rdy;

  modport master (output rxq_bits, output rxq_aux_bits, output rxq_val, input rxq_rdy);
  modport slave  (input rxq_bits, input rxq_aux_bits, input rxq_val, output rxq_rdy);
endinterface

// File: rtl/eth_rx_word_packer.sv
// Packs MAC receive bytes into 64-bit little-endian rxq words tagged with count/last/error aux bits.
// Define ETH_RX_STATS_EN to build the saturating frame and drop counters.
module eth_rx_word_packer #(
  parameter int  FIFO_DEPTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_val,
  input  logic                        rx_last,
  input  logic                        rx_err,
  eth_rx_word_packer_if.master        rxq,
  output logic [31:0]                 stat_frames,
  output logic [15:0]                 stat_drops
);

  localparam int AW = CNT_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DROP    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t          state_r;
  logic [63:0]     asm_r;
  logic [2:0]      idx_r;
  logic            err_r;
  logic            marker_pend_r;

  logic [71:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [63:0]     rxq_bits_r;
  logic [7:0]      rxq_aux_r;
  logic            rxq_val_r;

  logic            pack_s;
  logic [63:0]     word_s;
  logic            frame_push_s;
  logic            frame_err_s;
  logic            push_req_s;
  logic [63:0]     push_word_s;
  logic [7:0]      push_aux_s;
  logic            full_s;
  logic            pop_s;
  logic            room_s;
  logic            push_ok_s;
  logic            frame_ok_s;
  logic            frame_rej_s;
  logic            discard_s;
  logic            arm_s;
  logic [AW-1:0]   rd_next_s;
  logic [CNT_W-1:0] count_next_s;
  logic [CNT_W-1:0] left_s;

  // Byte packing, push arbitration between marker and frame words, FIFO bookkeeping.
  always_comb begin
    pack_s       = rx_val && ((state_r == ST_RECV) || ((state_r == ST_IDLE) && !marker_pend_r));
    word_s       = asm_r | ({56'd0, rx_data} << {idx_r, 3'b000});
    frame_push_s = pack_s && ((idx_r == 3'd7) || rx_last);
    frame_err_s  = err_r | rx_err;
    push_req_s   = marker_pend_r | frame_push_s;
    if (marker_pend_r) begin
      push_word_s = 64'd0;
      push_aux_s  = 8'hC0;
    end else begin
      push_word_s = word_s;
      push_aux_s  = {frame_err_s, rx_last, 3'b000, idx_r};
    end
    full_s       = (count_r == CNT_W'(FIFO_DEPTH));
    pop_s        = rxq_val_r & rxq.rxq_rdy;
    room_s       = ~full_s | pop_s;
    push_ok_s    = push_req_s & room_s;
    frame_ok_s   = frame_push_s & ~marker_pend_r & room_s;
    frame_rej_s  = frame_push_s & ~frame_ok_s;
    discard_s    = rx_val && (state_r == ST_IDLE) && marker_pend_r;
    arm_s        = (frame_rej_s & rx_last) | ((state_r == ST_DROP) & rx_val & rx_last);
    rd_next_s    = rd_ptr_r + AW'(pop_s);
    count_next_s = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_s);
    left_s       = count_r - CNT_W'(pop_s);
  end

  // Frame state machine, byte assembler, sticky error and marker-pending flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      asm_r         <= 64'd0;
      idx_r         <= 3'd0;
      err_r         <= 1'b0;
      marker_pend_r <= 1'b0;
    end else begin
      if (rx_val) begin
        err_r <= rx_last ? 1'b0 : frame_err_s;
      end else begin
        err_r <= err_r;
      end

      if (pack_s && frame_push_s) begin
        asm_r <= 64'd0;
        idx_r <= 3'd0;
      end else if (pack_s) begin
        asm_r <= word_s;
        idx_r <= idx_r + 3'd1;
      end else begin
        asm_r <= asm_r;
        idx_r <= idx_r;
      end

      // A truncated frame always owes the consumer one terminating error word.
      if (arm_s) begin
        marker_pend_r <= 1'b1;
      end else if (marker_pend_r && push_ok_s) begin
        marker_pend_r <= 1'b0;
      end else begin
        marker_pend_r <= marker_pend_r;
      end

      case (state_r)
        ST_IDLE, ST_RECV: begin
          if (discard_s) begin
            state_r <= rx_last ? ST_IDLE : ST_DISCARD;
          end else if (pack_s && frame_rej_s) begin
            state_r <= rx_last ? ST_IDLE : ST_DROP;
          end else if (pack_s) begin
            state_r <= rx_last ? ST_IDLE : ST_RECV;
          end else begin
            state_r <= state_r;
          end
        end
        ST_DROP, ST_DISCARD: begin
          if (rx_val && rx_last) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Word storage; contents are meaningless outside the pointer window so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= {push_aux_s, push_word_s};
    end
  end

  // Pointers, occupancy and the registered first-word-fall-through head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      rxq_val_r  <= 1'b0;
      rxq_bits_r <= 64'd0;
      rxq_aux_r  <= 8'd0;
    end else begin
      rd_ptr_r  <= rd_next_s;
      wr_ptr_r  <= wr_ptr_r + AW'(push_ok_s);
      count_r   <= count_next_s;
      rxq_val_r <= (count_next_s != '0);
      // With nothing left behind the head, a new word bypasses the array.
      if ((left_s == '0) && push_ok_s) begin
        {rxq_aux_r, rxq_bits_r} <= {push_aux_s, push_word_s};
      end else if ((left_s != '0) && pop_s) begin
        {rxq_aux_r, rxq_bits_r} <= mem_r[rd_next_s];
      end else begin
        {rxq_aux_r, rxq_bits_r} <= {rxq_aux_r, rxq_bits_r};
      end
    end
  end

  assign rxq.rxq_bits     = rxq_bits_r;
  assign rxq.rxq_aux_bits = rxq_aux_r;
  assign rxq.rxq_val      = rxq_val_r;

`ifdef ETH_RX_STATS_EN
  logic [31:0] frames_r;
  logic [15:0] drops_r;
  logic        frame_done_s;
  logic        drop_evt_s;

  assign frame_done_s = frame_ok_s & rx_last & ~frame_err_s;
  assign drop_evt_s   = frame_rej_s | discard_s;

  // Saturating delivered-frame and truncated/discarded-frame counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames_r <= 32'd0;
      drops_r  <= 16'd0;
    end else begin
      if (frame_done_s && (frames_r != {32{1'b1}})) begin
        frames_r <= frames_r + 32'd1;
      end else begin
        frames_r <= frames_r;
      end
      if (drop_evt_s && (drops_r != {16{1'b1}})) begin
        drops_r <= drops_r + 16'd1;
      end else begin
        drops_r <= drops_r;
      end
    end
  end

  assign stat_frames = frames_r;
  assign stat_drops  = drops_r;
`else
  assign stat_frames = 32'd0;
  assign stat_drops  = 16'd0;
`endif

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Scoreboard bench for eth_rx_word_packer: expected words are queued as bytes are driven
// and compared against the rxq head on every falling edge.
module tb_eth_rx_word_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_val;
  logic        rx_last;
  logic        rx_err;
  logic [31:0] stat_frames;
  logic [15:0] stat_drops;

  eth_rx_word_packer_if rxq_if ();

  eth_rx_word_packer #(.FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_val      (rx_val),
    .rx_last     (rx_last),
    .rx_err      (rx_err),
    .rxq         (rxq_if),
    .stat_frames (stat_frames),
    .stat_drops  (stat_drops)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [71:0] exp_q [$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Head word must always match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && rxq_if.rxq_val) begin
      if (exp_q.size() == 0) begin
        check_val("extra_word_val", {63'd0, rxq_if.rxq_val}, 64'd0);
      end else begin
        check_val("rxq_bits", rxq_if.rxq_bits, exp_q[0][63:0]);
        check_val("rxq_aux", {56'd0, rxq_if.rxq_aux_bits}, {56'd0, exp_q[0][71:64]});
        if (rxq_if.rxq_rdy) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [63:0] exp_stat(input int v);
`ifdef ETH_RX_STATS_EN
    return 64'(v);
`else
    return 64'd0;
`endif
  endfunction

  task automatic check_stats(input int frames, input int drops);
    check_val("stat_frames", {32'd0, stat_frames}, exp_stat(frames));
    check_val("stat_drops", {48'd0, stat_drops}, exp_stat(drops));
  endtask

  // Drives nsend bytes of a len-byte frame; the first keep words (keep<0: all) are expected.
  task automatic send_frame(input int first, input int len, input int nsend, input int err_pos,
                            input int keep, input bit rdy_on_push, input int gap_at);
    logic [63:0] w      = 64'd0;
    int          lane   = 0;
    int          words  = 0;
    bit          sticky = 1'b0;
    logic [7:0]  b;
    bit          lst, er, push_now;
    for (int i = 0; i < nsend; i++) begin
      if (i == gap_at) begin
        rx_val  = 1'b0;
        rx_last = 1'b1;
        @(posedge clk); #1;
      end
      b        = 8'(first + i);
      lst      = (i == len - 1);
      er       = (i == err_pos);
      w        = w | (64'(b) << (8 * lane));
      push_now = (lane == 7) || lst;
      if (push_now) begin
        if (keep < 0 || words < keep)
          exp_q.push_back({sticky | er, lst, 3'b000, 3'(lane), w});
        words++;
        w    = 64'd0;
        lane = 0;
      end else begin
        lane++;
      end
      sticky  = lst ? 1'b0 : (sticky | er);
      rx_val  = 1'b1;
      rx_data = b;
      rx_last = lst;
      rx_err  = er;
      if (rdy_on_push) rxq_if.rxq_rdy = push_now;
      @(posedge clk); #1;
    end
    rx_val  = 1'b0;
    rx_last = 1'b0;
    rx_err  = 1'b0;
    if (rdy_on_push) rxq_if.rxq_rdy = 1'b0;
  endtask

  task automatic drain(input int budget);
    rxq_if.rxq_rdy = 1'b1;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check_val("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    rx_data        = 8'd0;
    rx_val         = 1'b0;
    rx_last        = 1'b0;
    rx_err         = 1'b0;
    rxq_if.rxq_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_val("reset_val", {63'd0, rxq_if.rxq_val}, 64'd0);
    check_val("reset_bits", rxq_if.rxq_bits, 64'd0);
    check_val("reset_aux", {56'd0, rxq_if.rxq_aux_bits}, 64'd0);
    check_stats(0, 0);

    // 14-byte frame with fixed expected words
    rxq_if.rxq_rdy = 1'b1;
    exp_q.push_back({8'h07, 64'h0706050403020100});
    exp_q.push_back({8'h45, 64'h00000D0C0B0A0908});
    send_frame(0, 14, 14, -1, 0, 1'b0, -1);
    drain(20);
    check_stats(1, 0);

    // 16-byte frame with a MAC error in the second word
    send_frame(8'h10, 16, 16, 11, -1, 1'b0, -1);
    drain(20);
    check_stats(1, 0);

    // single-byte frames and a stray rx_last between bytes
    send_frame(8'hAB, 1, 1, 0, -1, 1'b0, -1);
    send_frame(8'hCD, 1, 1, -1, -1, 1'b0, -1);
    send_frame(8'h50, 10, 10, -1, -1, 1'b0, 3);
    drain(20);
    check_stats(3, 0);

    // overflow: 8 words held, rest dropped, marker owed
    rxq_if.rxq_rdy = 1'b0;
    send_frame(0, 100, 100, -1, 8, 1'b0, -1);
    exp_q.push_back({8'hC0, 64'd0});
    check_stats(3, 1);
    // new frame while the marker is still pending is discarded whole
    send_frame(8'h80, 20, 20, -1, 0, 1'b0, -1);
    check_stats(3, 2);
    drain(60);
    send_frame(8'hC0, 12, 12, -1, -1, 1'b0, -1);
    drain(20);
    check_stats(4, 2);

    // full FIFO with push and pop on the same edge, stalls in between
    rxq_if.rxq_rdy = 1'b0;
    send_frame(8'h00, 64, 64, -1, -1, 1'b0, -1);
    send_frame(8'h40, 64, 64, -1, -1, 1'b1, -1);
    check_stats(6, 2);
    drain(60);

    // reset mid-frame with three words queued
    rxq_if.rxq_rdy = 1'b0;
    send_frame(8'h30, 40, 24, -1, -1, 1'b0, -1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("midrst_val", {63'd0, rxq_if.rxq_val}, 64'd0);
    check_stats(0, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n        = 1'b1;
    rxq_if.rxq_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("post_rst_val", {63'd0, rxq_if.rxq_val}, 64'd0);
    send_frame(8'h48, 16, 16, -1, -1, 1'b0, -1);
    drain(20);
    check_stats(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
